// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared funct3 encodings, FSM state type and access-size helpers for the MEM-stage load/store engine
package mem_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } mau_state_e;

    // size is funct3[1:0]: 00 byte, 01 half, anything else treated as word
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
        case (size)
            2'b00:   return 1'b0;
            2'b01:   return offset[0];
            default: return (offset != 2'b00);
        endcase
    endfunction

    function automatic logic [3:0] store_strb(input logic [1:0] size, input logic [1:0] offset);
        case (size)
            2'b00:   return 4'b0001 << offset;
            2'b01:   return 4'b0011 << {offset[1], 1'b0};
            default: return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// rtl/lsu_load_ext.sv - selects the addressed byte/half of a read word and sign- or zero-extends it
module lsu_load_ext
    import mem_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] rdata,
    input  logic [2:0]        funct3,
    input  logic [1:0]        offset,
    output logic [DATA_W-1:0] ext
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        is_signed;

    assign is_signed = ~funct3[2];

    // pick the lane addressed by the low address bits, then extend to full width
    always_comb begin
        byte_sel = rdata[7:0];
        case (offset)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
        case (funct3[1:0])
            2'b00:   ext = {{(DATA_W-8){is_signed & byte_sel[7]}}, byte_sel};
            2'b01:   ext = {{(DATA_W-16){is_signed & half_sel[15]}}, half_sel};
            default: ext = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage load/store engine driving a req/ack Dcache port and the pipeline stall
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read_MEM,
    input  logic              mem_write_MEM,
    input  logic [2:0]        funct3_MEM,
    input  logic [DATA_W-1:0] alu_result_MEM,
    input  logic [DATA_W-1:0] store_data_MEM,
    input  logic              Istall,
    input  logic              wfi_stall,
    output logic              dc_req,
    output logic              dc_we,
    output logic [DATA_W-1:0] dc_addr,
    output logic [DATA_W-1:0] dc_wdata,
    output logic [3:0]        dc_wstrb,
    input  logic              dc_ack,
    input  logic [DATA_W-1:0] dc_rdata,
    output logic [DATA_W-1:0] Dcache_out_ext,
    output logic              Dstall,
    output logic              misalign_exc,
    output logic              bus_err
);

    localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

    mau_state_e        state_q;
    logic [CNT_W-1:0]  cnt_q;

    // request captured at issue so WAIT drives a stable transaction
    logic              rd_q;
    logic              we_q;
    logic [2:0]        f3_q;
    logic [DATA_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [3:0]        wstrb_q;

    logic              access;
    logic              misaligned;
    logic              in_idle;
    logic              in_wait;
    logic              issue;
    logic              timeout;
    logic              req_we;
    logic [3:0]        req_wstrb;
    logic [DATA_W-1:0] req_wdata;
    logic [2:0]        cur_f3;
    logic [DATA_W-1:0] cur_addr;
    logic [DATA_W-1:0] load_ext;

    assign access     = mem_read_MEM | mem_write_MEM;
    assign misaligned = is_misaligned(funct3_MEM[1:0], alu_result_MEM[1:0]);
    assign in_idle    = (state_q == IDLE);
    assign in_wait    = (state_q == WAIT);
    assign issue      = in_idle & access & ~misaligned;
    assign timeout    = in_wait & (cnt_q == CNT_W'(ACK_TIMEOUT));

    // a read takes priority when both controls are set
    assign req_we    = mem_write_MEM & ~mem_read_MEM;
    assign req_wstrb = store_strb(funct3_MEM[1:0], alu_result_MEM[1:0]);

    // replicate store data across lanes so the strobes alone pick the bytes written
    always_comb begin
        case (funct3_MEM[1:0])
            2'b00:   req_wdata = {4{store_data_MEM[7:0]}};
            2'b01:   req_wdata = {2{store_data_MEM[15:0]}};
            default: req_wdata = store_data_MEM;
        endcase
    end

    assign cur_f3   = in_idle ? funct3_MEM     : f3_q;
    assign cur_addr = in_idle ? alu_result_MEM : addr_q;

    assign dc_we    = in_idle ? req_we    : we_q;
    assign dc_wdata = in_idle ? req_wdata : wdata_q;
    assign dc_wstrb = in_idle ? req_wstrb : wstrb_q;
    assign dc_addr  = {cur_addr[DATA_W-1:2], 2'b00};

    // handshake and flags are masked during reset so an abandoned request disappears at once
    assign dc_req       = ~rst & (issue | (in_wait & ~timeout));
    assign Dstall       = ~rst & (issue | in_wait);
    assign misalign_exc = ~rst & in_idle & access & misaligned;
    assign bus_err      = ~rst & timeout;

    lsu_load_ext #(
        .DATA_W (DATA_W)
    ) u_load_ext (
        .rdata  (dc_rdata),
        .funct3 (cur_f3),
        .offset (cur_addr[1:0]),
        .ext    (load_ext)
    );

    // access FSM: issue, wait for ack or timeout, then hold in DONE while the front end is stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            rd_q           <= 1'b0;
            we_q           <= 1'b0;
            f3_q           <= '0;
            addr_q         <= '0;
            wdata_q        <= '0;
            wstrb_q        <= '0;
            Dcache_out_ext <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (access) begin
                        if (misaligned) begin
                            Dcache_out_ext <= '0;
                        end else begin
                            rd_q    <= mem_read_MEM;
                            we_q    <= req_we;
                            f3_q    <= funct3_MEM;
                            addr_q  <= alu_result_MEM;
                            wdata_q <= req_wdata;
                            wstrb_q <= req_wstrb;
                            cnt_q   <= '0;
                            if (dc_ack) begin
                                state_q <= DONE;
                                if (mem_read_MEM) begin
                                    Dcache_out_ext <= load_ext;
                                end
                            end else begin
                                state_q <= WAIT;
                            end
                        end
                    end
                end
                WAIT: begin
                    if (timeout) begin
                        state_q <= DONE;
                        if (rd_q) begin
                            Dcache_out_ext <= '0;
                        end
                    end else if (dc_ack) begin
                        state_q <= DONE;
                        if (rd_q) begin
                            Dcache_out_ext <= load_ext;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (!(Istall | wfi_stall)) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed self-checking bench for mem_access_unit
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read_MEM;
    logic        mem_write_MEM;
    logic [2:0]  funct3_MEM;
    logic [31:0] alu_result_MEM;
    logic [31:0] store_data_MEM;
    logic        Istall;
    logic        wfi_stall;
    logic        dc_req;
    logic        dc_we;
    logic [31:0] dc_addr;
    logic [31:0] dc_wdata;
    logic [3:0]  dc_wstrb;
    logic        dc_ack;
    logic [31:0] dc_rdata;
    logic [31:0] Dcache_out_ext;
    logic        Dstall;
    logic        misalign_exc;
    logic        bus_err;

    int checks   = 0;
    int failures = 0;

    mem_access_unit #(
        .DATA_W      (32),
        .ACK_TIMEOUT (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .mem_read_MEM   (mem_read_MEM),
        .mem_write_MEM  (mem_write_MEM),
        .funct3_MEM     (funct3_MEM),
        .alu_result_MEM (alu_result_MEM),
        .store_data_MEM (store_data_MEM),
        .Istall         (Istall),
        .wfi_stall      (wfi_stall),
        .dc_req         (dc_req),
        .dc_we          (dc_we),
        .dc_addr        (dc_addr),
        .dc_wdata       (dc_wdata),
        .dc_wstrb       (dc_wstrb),
        .dc_ack         (dc_ack),
        .dc_rdata       (dc_rdata),
        .Dcache_out_ext (Dcache_out_ext),
        .Dstall         (Dstall),
        .misalign_exc   (misalign_exc),
        .bus_err        (bus_err)
    );

    always #5 clk = ~clk;

    task automatic present(input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] sdata, input logic [31:0] rdata);
        @(negedge clk);
        mem_read_MEM   = rd;
        mem_write_MEM  = wr;
        funct3_MEM     = f3;
        alu_result_MEM = addr;
        store_data_MEM = sdata;
        dc_rdata       = rdata;
        dc_ack         = 1'b0;
        #1;
    endtask

    // counts Dstall cycles of the presented access; stalls = -1 if it never ends
    task automatic run_access(input int ack_at, output int stalls);
        bit ended = 0;
        stalls = 0;
        for (int i = 0; i < 16 && !ended; i++) begin
            if (i > 0) @(negedge clk);
            dc_ack = (i == ack_at);
            #1;
            if (Dstall === 1'b1) stalls++;
            else ended = 1;
        end
        dc_ack = 1'b0;
        if (!ended) stalls = -1;
    endtask

    task automatic finish_access();
        @(negedge clk);
        mem_read_MEM  = 1'b0;
        mem_write_MEM = 1'b0;
        dc_ack        = 1'b0;
        Istall        = 1'b0;
        wfi_stall     = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        mem_read_MEM   = 1'b1;
        funct3_MEM     = 3'b010;
        alu_result_MEM = 32'h100;
        @(negedge clk);
        #1;
        checks++; if (dc_req !== 1'b0) begin failures++; $display("FAIL reset_dc_req: got %b want 0", dc_req); end
        checks++; if (Dstall !== 1'b0) begin failures++; $display("FAIL reset_dstall: got %b want 0", Dstall); end
        checks++; if (misalign_exc !== 1'b0 || bus_err !== 1'b0) begin failures++; $display("FAIL reset_flags: got %b%b want 00", misalign_exc, bus_err); end
        checks++; if (Dcache_out_ext !== 32'h0) begin failures++; $display("FAIL reset_out: got %h want 00000000", Dcache_out_ext); end
        @(negedge clk);
        rst          = 1'b0;
        mem_read_MEM = 1'b0;
        #1;
    endtask

    task automatic test_lb_wait();
        int s;
        present(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF_1234);
        checks++; if (dc_req !== 1'b1) begin failures++; $display("FAIL lb_req: got %b want 1", dc_req); end
        checks++; if (dc_addr !== 32'h100) begin failures++; $display("FAIL lb_addr: got %h want 00000100", dc_addr); end
        checks++; if (dc_we !== 1'b0) begin failures++; $display("FAIL lb_we: got %b want 0", dc_we); end
        run_access(2, s);
        checks++; if (s !== 3) begin failures++; $display("FAIL lb_stall_cycles: got %0d want 3", s); end
        checks++; if (Dcache_out_ext !== 32'hFFFF_FF80) begin failures++; $display("FAIL lb_out: got %h want ffffff80", Dcache_out_ext); end
        finish_access();
    endtask

    task automatic test_lhu_fast();
        int s;
        present(1'b1, 1'b0, 3'b101, 32'h102, 32'h0, 32'h8001_0000);
        run_access(0, s);
        checks++; if (s !== 1) begin failures++; $display("FAIL lhu_stall_cycles: got %0d want 1", s); end
        checks++; if (Dcache_out_ext !== 32'h0000_8001) begin failures++; $display("FAIL lhu_out: got %h want 00008001", Dcache_out_ext); end
        finish_access();
    endtask

    task automatic test_store();
        int s;
        present(1'b0, 1'b1, 3'b001, 32'h206, 32'h0000_ABCD, 32'hFFFF_FFFF);
        checks++; if (dc_we !== 1'b1) begin failures++; $display("FAIL sh_we: got %b want 1", dc_we); end
        checks++; if (dc_wstrb !== 4'b1100) begin failures++; $display("FAIL sh_wstrb: got %b want 1100", dc_wstrb); end
        checks++; if (dc_wdata !== 32'hABCD_ABCD) begin failures++; $display("FAIL sh_wdata: got %h want abcdabcd", dc_wdata); end
        checks++; if (dc_addr !== 32'h204) begin failures++; $display("FAIL sh_addr: got %h want 00000204", dc_addr); end
        run_access(0, s);
        checks++; if (Dcache_out_ext !== 32'h0000_8001) begin failures++; $display("FAIL sh_out_held: got %h want 00008001", Dcache_out_ext); end
        finish_access();
        present(1'b0, 1'b1, 3'b000, 32'h301, 32'h1234_5678, 32'h0);
        checks++; if (dc_wstrb !== 4'b0010) begin failures++; $display("FAIL sb_wstrb: got %b want 0010", dc_wstrb); end
        checks++; if (dc_wdata !== 32'h7878_7878) begin failures++; $display("FAIL sb_wdata: got %h want 78787878", dc_wdata); end
        run_access(1, s);
        checks++; if (s !== 2) begin failures++; $display("FAIL sb_stall_cycles: got %0d want 2", s); end
        finish_access();
    endtask

    task automatic test_load_table();
        logic [2:0]  f3  [4] = '{3'b001, 3'b100, 3'b000, 3'b010};
        logic [31:0] ad  [4] = '{32'h102, 32'h101, 32'h102, 32'h100};
        logic [31:0] rd  [4] = '{32'h8001_0000, 32'h80FF_1234, 32'h80FF_1234, 32'hDEAD_BEEF};
        logic [31:0] exp [4] = '{32'hFFFF_8001, 32'h0000_0012, 32'hFFFF_FFFF, 32'hDEAD_BEEF};
        int s;
        for (int k = 0; k < 4; k++) begin
            present(1'b1, 1'b0, f3[k], ad[k], 32'h0, rd[k]);
            run_access(0, s);
            checks++; if (Dcache_out_ext !== exp[k]) begin failures++; $display("FAIL load_row%0d: got %h want %h", k, Dcache_out_ext, exp[k]); end
            finish_access();
        end
    endtask

    task automatic test_misaligned();
        present(1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 32'h5555_5555);
        checks++; if (dc_req !== 1'b0) begin failures++; $display("FAIL mis_req: got %b want 0", dc_req); end
        checks++; if (misalign_exc !== 1'b1) begin failures++; $display("FAIL mis_exc: got %b want 1", misalign_exc); end
        checks++; if (Dstall !== 1'b0) begin failures++; $display("FAIL mis_dstall: got %b want 0", Dstall); end
        finish_access();
        checks++; if (misalign_exc !== 1'b0) begin failures++; $display("FAIL mis_exc_pulse: got %b want 0", misalign_exc); end
        checks++; if (Dcache_out_ext !== 32'h0) begin failures++; $display("FAIL mis_out: got %h want 00000000", Dcache_out_ext); end
    endtask

    task automatic test_timeout();
        int s;
        int hit = -1;
        present(1'b1, 1'b0, 3'b010, 32'h3FC, 32'h0, 32'hCAFE_F00D);
        run_access(0, s);
        checks++; if (Dcache_out_ext !== 32'hCAFE_F00D) begin failures++; $display("FAIL to_pre_out: got %h want cafef00d", Dcache_out_ext); end
        finish_access();
        present(1'b1, 1'b0, 3'b010, 32'h400, 32'h0, 32'h1234_5678);
        for (int i = 0; i < 20 && hit < 0; i++) begin
            if (i > 0) begin @(negedge clk); #1; end
            if (bus_err === 1'b1) begin
                hit = i;
                checks++; if (dc_req !== 1'b0) begin failures++; $display("FAIL to_req_drop: got %b want 0", dc_req); end
            end
        end
        checks++; if (hit !== 5) begin failures++; $display("FAIL to_cycle: got %0d want 5", hit); end
        @(negedge clk);
        #1;
        checks++; if (Dstall !== 1'b0 || bus_err !== 1'b0) begin failures++; $display("FAIL to_after: got dstall=%b bus_err=%b want 0 0", Dstall, bus_err); end
        checks++; if (Dcache_out_ext !== 32'h0) begin failures++; $display("FAIL to_out: got %h want 00000000", Dcache_out_ext); end
        finish_access();
    endtask

    task automatic test_done_istall();
        present(1'b1, 1'b0, 3'b010, 32'h500, 32'h0, 32'h1111_1111);
        dc_ack = 1'b1;
        #1;
        checks++; if (Dstall !== 1'b1) begin failures++; $display("FAIL ist_first: got %b want 1", Dstall); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            dc_ack = 1'b0;
            Istall = 1'b1;
            #1;
            checks++; if (dc_req !== 1'b0 || Dstall !== 1'b0) begin failures++; $display("FAIL ist_hold%0d: got req=%b dstall=%b want 0 0", i, dc_req, Dstall); end
        end
        @(negedge clk);
        Istall = 1'b0;
        #1;
        checks++; if (dc_req !== 1'b0) begin failures++; $display("FAIL ist_release: got %b want 0", dc_req); end
        checks++; if (Dcache_out_ext !== 32'h1111_1111) begin failures++; $display("FAIL ist_out: got %h want 11111111", Dcache_out_ext); end
        finish_access();
    endtask

    task automatic test_reset_mid_wait();
        int s;
        present(1'b1, 1'b0, 3'b010, 32'h600, 32'h0, 32'h2222_2222);
        @(negedge clk);
        #1;
        checks++; if (dc_req !== 1'b1) begin failures++; $display("FAIL rmw_waiting: got %b want 1", dc_req); end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (dc_req !== 1'b0 || Dstall !== 1'b0) begin failures++; $display("FAIL rmw_forced: got req=%b dstall=%b want 0 0", dc_req, Dstall); end
        @(negedge clk);
        rst          = 1'b0;
        mem_read_MEM = 1'b0;
        #1;
        checks++; if (dc_req !== 1'b0 || Dstall !== 1'b0) begin failures++; $display("FAIL rmw_after: got req=%b dstall=%b want 0 0", dc_req, Dstall); end
        checks++; if (Dcache_out_ext !== 32'h0) begin failures++; $display("FAIL rmw_out: got %h want 00000000", Dcache_out_ext); end
        present(1'b1, 1'b0, 3'b100, 32'h601, 32'h0, 32'h0000_AB00);
        checks++; if (dc_req !== 1'b1) begin failures++; $display("FAIL rmw_idle_issue: got %b want 1", dc_req); end
        run_access(0, s);
        checks++; if (Dcache_out_ext !== 32'h0000_00AB) begin failures++; $display("FAIL rmw_reload: got %h want 000000ab", Dcache_out_ext); end
        finish_access();
    endtask

    task automatic test_back_to_back();
        int s;
        present(1'b1, 1'b1, 3'b010, 32'h700, 32'hFFFF_FFFF, 32'h5A5A_5A5A);
        checks++; if (dc_we !== 1'b0) begin failures++; $display("FAIL b2b_read_wins: got %b want 0", dc_we); end
        run_access(0, s);
        checks++; if (Dcache_out_ext !== 32'h5A5A_5A5A) begin failures++; $display("FAIL b2b_first: got %h want 5a5a5a5a", Dcache_out_ext); end
        finish_access();
        present(1'b1, 1'b0, 3'b001, 32'h706, 32'h0, 32'h7FFF_0000);
        run_access(3, s);
        checks++; if (s !== 4) begin failures++; $display("FAIL b2b_stall_cycles: got %0d want 4", s); end
        checks++; if (Dcache_out_ext !== 32'h0000_7FFF) begin failures++; $display("FAIL b2b_second: got %h want 00007fff", Dcache_out_ext); end
        finish_access();
    endtask

    initial begin
        rst            = 1'b1;
        mem_read_MEM   = 1'b0;
        mem_write_MEM  = 1'b0;
        funct3_MEM     = 3'b000;
        alu_result_MEM = 32'h0;
        store_data_MEM = 32'h0;
        Istall         = 1'b0;
        wfi_stall      = 1'b0;
        dc_ack         = 1'b0;
        dc_rdata       = 32'h0;
        test_reset();
        test_lb_wait();
        test_lhu_fast();
        test_store();
        test_load_table();
        test_misaligned();
        test_timeout();
        test_done_istall();
        test_reset_mid_wait();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
